// File: rtl/ternary_spi_slave.sv
// Balanced-ternary SPI responder: trit-serial MOSI in, trit-serial MISO out,
// with parallel rx words out and a one-deep valid/ready reply holding register.
module ternary_spi_slave #(
  parameter int TRITS = 6
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [1:0]           I_sck,
  input  logic [1:0]           I_mosi,
  output logic [1:0]           O_miso,
  output logic [2*TRITS-1:0]   O_rx_data,
  output logic                 O_rx_valid,
  input  logic [2*TRITS-1:0]   I_tx_data,
  input  logic                 I_tx_valid,
  output logic                 O_tx_ready,
  output logic                 O_err
);

  localparam int W  = 2 * TRITS;
  localparam int CW = $clog2(TRITS + 1);

  localparam logic [1:0] T_ZERO  = 2'b00;
  localparam logic [1:0] T_PLUS  = 2'b01;
  localparam logic [1:0] T_MINUS = 2'b10;
  localparam logic [1:0] T_ILL   = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [1:0]   sckMeta_q, sckSync_q, sckPrev_q;
  logic [1:0]   mosiMeta_q, mosiSync_q;
  state_t       state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-3:0] rxShift_q, rxShift_d;
  logic [W-1:0] rxData_q, rxData_d;
  logic         rxValid_q, rxValid_d;
  logic [W-1:0] txShift_q, txShift_d;
  logic [W-1:0] hold_q, hold_d;
  logic         holdFull_q, holdFull_d;
  logic         wordDone_q, wordDone_d;
  logic [1:0]   miso_q, miso_d;
  logic         err_q, err_d;

  logic [1:0]   sckCur, sckLast, mosiTrit;
  logic         sckIllegal, mosiIllegal, frameStart, sample, shift, accept, load;
  logic [W-1:0] rxNext;

  // Illegal sck codes read as ZERO for edge detection; the error fires once on entry.
  assign sckCur      = (sckSync_q == T_ILL) ? T_ZERO : sckSync_q;
  assign sckLast     = (sckPrev_q == T_ILL) ? T_ZERO : sckPrev_q;
  assign sckIllegal  = (sckSync_q == T_ILL) && (sckPrev_q != T_ILL);
  assign frameStart  = (sckCur == T_MINUS) && (sckLast != T_MINUS);
  assign sample      = (sckLast == T_ZERO) && (sckCur == T_PLUS);
  assign shift       = (sckLast == T_PLUS) && (sckCur == T_ZERO);
  assign mosiIllegal = (mosiSync_q == T_ILL);
  assign mosiTrit    = mosiIllegal ? T_ZERO : mosiSync_q;
  assign accept      = I_tx_valid && !holdFull_q;
  assign rxNext      = {rxShift_q, mosiTrit};

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      sckMeta_q  <= T_ZERO;
      sckSync_q  <= T_ZERO;
      sckPrev_q  <= T_ZERO;
      mosiMeta_q <= T_ZERO;
      mosiSync_q <= T_ZERO;
    end else begin
      sckMeta_q  <= I_sck;
      sckSync_q  <= sckMeta_q;
      sckPrev_q  <= sckSync_q;
      mosiMeta_q <= I_mosi;
      mosiSync_q <= mosiMeta_q;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      txShift_q  <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      wordDone_q <= 1'b0;
      miso_q     <= T_ZERO;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      txShift_q  <= txShift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      wordDone_q <= wordDone_d;
      miso_q     <= miso_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    txShift_d  = txShift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    wordDone_d = wordDone_q;
    err_d      = sckIllegal;
    load       = 1'b0;

    if (accept) begin
      hold_d     = I_tx_data;
      holdFull_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frameStart) begin
          state_d    = ACTIVE;
          load       = 1'b1;
          count_d    = '0;
          wordDone_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (frameStart) begin
          load       = 1'b1;
          count_d    = '0;
          wordDone_d = 1'b0;
        end else begin
          if (sample) begin
            rxShift_d = rxNext[W-3:0];
            err_d     = err_d | mosiIllegal;
            if (count_q == CW'(TRITS - 1)) begin
              count_d    = '0;
              rxData_d   = rxNext;
              rxValid_d  = 1'b1;
              wordDone_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
          // The SHIFT closing a word reloads instead of advancing.
          if (shift) begin
            if (wordDone_q) begin
              load       = 1'b1;
              wordDone_d = 1'b0;
            end else begin
              txShift_d = {txShift_q[W-3:0], T_ZERO};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A word accepted this cycle cannot be used: accept implies holding was empty.
    if (load) begin
      if (holdFull_q) begin
        txShift_d  = hold_q;
        holdFull_d = 1'b0;
      end else begin
        txShift_d = '0;
        err_d     = 1'b1;
      end
    end

    miso_d = (state_q == ACTIVE) ? txShift_q[W-1 -: 2] : T_ZERO;
  end

  assign O_miso     = miso_q;
  assign O_rx_data  = rxData_q;
  assign O_rx_valid = rxValid_q;
  assign O_tx_ready = !holdFull_q;
  assign O_err      = err_q;

endmodule
